// File: rtl/dino_motion_pkg.sv
// Shared definitions for the dino motion controller: posture encodings,
// default physics constants and a counter-width helper.
package dino_motion_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUCK = 2'd1,
    ST_AIR  = 2'd2,
    ST_LAND = 2'd3
  } state_t;

  localparam int DEF_Y_W        = 8;
  localparam int DEF_JUMP_VEL   = 4;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_LAND_TICKS = 2;

  // Bits needed to hold a countdown from n-1 to 0 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dino_motion.sv
// Player-motion controller: turns debounced jump/duck levels into the dino's
// height and posture, advancing once per non-frozen frame tick.
module dino_motion
  import dino_motion_pkg::*;
#(
  parameter int Y_W        = DEF_Y_W,
  parameter int JUMP_VEL   = DEF_JUMP_VEL,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int LAND_TICKS = DEF_LAND_TICKS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_tick,
  input  logic           i_jump,
  input  logic           i_duck,
  input  logic           i_freeze,
  output logic [Y_W-1:0] o_y,
  output logic           o_ducking,
  output logic           o_airborne,
  output logic           o_landed
);

  localparam int LC_W = cnt_w(LAND_TICKS);

  localparam logic signed [Y_W:0]   VEL_TAKEOFF = (Y_W+1)'(JUMP_VEL);
  localparam logic signed [Y_W:0]   G_NORMAL    = (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W:0]   G_DUCK      = (Y_W+1)'(2 * GRAVITY);
  localparam logic signed [Y_W+1:0] S_MAX       = (Y_W+2)'((2 ** Y_W) - 1);
  localparam logic [LC_W-1:0]       LC_INIT     = LC_W'(LAND_TICKS - 1);

  state_t                 state, state_n;
  logic [Y_W-1:0]         y, y_n;
  logic signed [Y_W:0]    vel, vel_n;
  logic [LC_W-1:0]        land_cnt, land_cnt_n;
  logic                   landed, landed_n;
  logic                   jump_prev;
  logic                   jump_pend, jump_pend_n;

  logic                   tick_en;
  logic                   jump_rise;
  logic                   on_ground_ready;
  logic signed [Y_W:0]    g;
  logic signed [Y_W+1:0]  s;

  assign tick_en         = i_tick & ~i_freeze;
  assign jump_rise       = i_jump & ~jump_prev;
  assign on_ground_ready = (state == ST_RUN) || (state == ST_DUCK);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    y_n         = y;
    vel_n       = vel;
    land_cnt_n  = land_cnt;
    landed_n    = 1'b0;
    jump_pend_n = jump_pend;
    g           = i_duck ? G_DUCK : G_NORMAL;
    s           = $signed({2'b00, y}) + $signed({vel[Y_W], vel});

    // A fresh edge wins over the tick clear so an edge arriving with the tick
    // is still honoured on the following tick.
    if (jump_rise && on_ground_ready) begin
      jump_pend_n = 1'b1;
    end else if (tick_en) begin
      jump_pend_n = 1'b0;
    end

    if (tick_en) begin
      unique case (state)
        ST_RUN: begin
          if (jump_pend) begin
            state_n = ST_AIR;
            vel_n   = VEL_TAKEOFF;
          end else if (i_duck) begin
            state_n = ST_DUCK;
          end
        end
        ST_DUCK: begin
          if (jump_pend) begin
            state_n = ST_AIR;
            vel_n   = VEL_TAKEOFF;
          end else if (!i_duck) begin
            state_n = ST_RUN;
          end
        end
        ST_AIR: begin
          if (s[Y_W+1] || (s == '0)) begin
            y_n        = '0;
            vel_n      = '0;
            state_n    = ST_LAND;
            land_cnt_n = LC_INIT;
            landed_n   = 1'b1;
          end else if (s > S_MAX) begin
            y_n   = {Y_W{1'b1}};
            vel_n = '0;
          end else begin
            y_n   = s[Y_W-1:0];
            vel_n = vel - g;
          end
        end
        ST_LAND: begin
          if (land_cnt == '0) begin
            state_n = i_duck ? ST_DUCK : ST_RUN;
          end else begin
            land_cnt_n = land_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      y         <= '0;
      vel       <= '0;
      land_cnt  <= '0;
      landed    <= 1'b0;
      jump_prev <= 1'b0;
      jump_pend <= 1'b0;
    end else begin
      state     <= state_n;
      y         <= y_n;
      vel       <= vel_n;
      land_cnt  <= land_cnt_n;
      landed    <= landed_n;
      jump_prev <= i_jump;
      jump_pend <= jump_pend_n;
    end
  end

  assign o_y        = y;
  assign o_ducking  = (state == ST_DUCK);
  assign o_airborne = (state == ST_AIR);
  assign o_landed   = landed;

endmodule

// File: tb/tb_dino_motion.sv
// Self-checking bench for dino_motion: directed scenarios plus random stimulus,
// two instances (default physics and a high take-off velocity) against a model.
module tb_dino_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, jump = 1'b0, duck = 1'b0, freeze = 1'b0;
  logic [7:0] y_a, y_b;
  logic       duck_a, air_a, land_a, duck_b, air_b, land_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dino_motion dut_a (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_jump(jump), .i_duck(duck),
    .i_freeze(freeze), .o_y(y_a), .o_ducking(duck_a), .o_airborne(air_a),
    .o_landed(land_a)
  );

  dino_motion #(.JUMP_VEL(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_jump(jump), .i_duck(duck),
    .i_freeze(freeze), .o_y(y_b), .o_ducking(duck_b), .o_airborne(air_b),
    .o_landed(land_b)
  );

  // Reference model: posture codes, height and velocity as plain integers.
  localparam int RUN = 0, DUCKING = 1, AIR = 2, LAND = 3;
  int m_st[2], m_y[2], m_vel[2], m_lc[2];
  bit m_pend[2], m_prev[2], m_landed[2];
  int jv[2] = '{4, 200};

  function automatic logic [10:0] model_out(input int k);
    return {8'(m_y[k]), m_st[k] == DUCKING, m_st[k] == AIR, m_landed[k]};
  endfunction

  function automatic logic [10:0] dut_out(input int k);
    return (k == 0) ? {y_a, duck_a, air_a, land_a} : {y_b, duck_b, air_b, land_b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = RUN; m_y[k] = 0; m_vel[k] = 0; m_lc[k] = 0;
      m_pend[k] = 0; m_prev[k] = 0; m_landed[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit tick_en, rise, pend_n;
    int s, g;
    tick_en = tick && !freeze;
    rise    = jump && !m_prev[k];
    pend_n  = m_pend[k];
    if (rise && (m_st[k] == RUN || m_st[k] == DUCKING)) pend_n = 1;
    else if (tick_en) pend_n = 0;
    m_landed[k] = 0;
    if (tick_en) begin
      case (m_st[k])
        RUN, DUCKING: begin
          if (m_pend[k]) begin
            m_st[k] = AIR; m_vel[k] = jv[k];
          end else begin
            m_st[k] = duck ? DUCKING : RUN;
          end
        end
        AIR: begin
          g = duck ? 2 : 1;
          s = m_y[k] + m_vel[k];
          if (s <= 0) begin
            m_y[k] = 0; m_vel[k] = 0; m_st[k] = LAND; m_lc[k] = 1; m_landed[k] = 1;
          end else if (s > 255) begin
            m_y[k] = 255; m_vel[k] = 0;
          end else begin
            m_y[k] = s; m_vel[k] = m_vel[k] - g;
          end
        end
        default: begin
          if (m_lc[k] == 0) m_st[k] = duck ? DUCKING : RUN;
          else m_lc[k] = m_lc[k] - 1;
        end
      endcase
    end
    m_pend[k] = pend_n;
    m_prev[k] = jump;
  endtask

  // Drive one clock cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit t, input bit j, input bit d, input bit f);
    tick = t; jump = j; duck = d; freeze = f;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  // Tick until both instances are back on the ground running (bounded).
  task automatic settle();
    for (int i = 0; i < 120; i++) begin
      if (m_st[0] == RUN && m_st[1] == RUN) break;
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_out(k) !== model_out(k)) begin
          bad++;
          $display("FAIL settle k=%0d got=%h want=%h", k, dut_out(k), model_out(k));
        end
      end
    end
    total++;
    if (air_a !== 1'b0 || air_b !== 1'b0 || m_st[0] != RUN || m_st[1] != RUN) begin
      bad++;
      $display("FAIL settle_timeout air_a=%b air_b=%b want both 0", air_a, air_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (dut_out(0) !== 11'd0 || dut_out(1) !== 11'd0) begin
      bad++;
      $display("FAIL reset_state got_a=%h got_b=%h want=000", dut_out(0), dut_out(1));
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      total++;
      if (dut_out(0) !== 11'd0 || dut_out(1) !== 11'd0) begin
        bad++;
        $display("FAIL idle_tick%0d got_a=%h got_b=%h want=000", i, dut_out(0), dut_out(1));
      end
    end
  endtask

  task automatic test_jump();
    int traj[9] = '{4, 7, 9, 10, 10, 9, 7, 4, 0};
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    total++;
    if (air_a !== 1'b1 || y_a !== 8'd0) begin
      bad++;
      $display("FAIL takeoff air=%b y=%0d want air=1 y=0", air_a, y_a);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0, 0);
      total++;
      if (y_a !== 8'(traj[i]) || land_a !== (i == 8)) begin
        bad++;
        $display("FAIL traj%0d y=%0d landed=%b want y=%0d landed=%b",
                 i, y_a, land_a, traj[i], (i == 8));
      end
    end
    cyc(0, 0, 0, 0);
    total++;
    if (land_a !== 1'b0) begin
      bad++;
      $display("FAIL landed_pulse_width landed=%b want 0", land_a);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++;
    if (dut_out(0) !== model_out(0) || m_st[0] != RUN) begin
      bad++;
      $display("FAIL land_exit got=%h want=%h", dut_out(0), model_out(0));
    end
    settle();
  endtask

  task automatic test_duck();
    cyc(1, 0, 1, 0);
    total++;
    if (duck_a !== 1'b1) begin
      bad++; $display("FAIL duck_enter ducking=%b want 1", duck_a);
    end
    cyc(1, 0, 0, 0);
    total++;
    if (duck_a !== 1'b0) begin
      bad++; $display("FAIL duck_release ducking=%b want 0", duck_a);
    end
    cyc(1, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    total++;
    if (air_a !== 1'b1 || duck_a !== 1'b0) begin
      bad++; $display("FAIL duck_jump air=%b ducking=%b want air=1 ducking=0", air_a, duck_a);
    end
    cyc(0, 0, 0, 0);
    settle();
  endtask

  task automatic test_apex_duck();
    int up[5]   = '{4, 7, 9, 10, 10};
    int down[4] = '{9, 6, 1, 0};
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      total++;
      if (y_a !== 8'(up[i])) begin
        bad++; $display("FAIL apex_up%0d y=%0d want %0d", i, y_a, up[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0);
      total++;
      if (y_a !== 8'(down[i]) || land_a !== (i == 3)) begin
        bad++;
        $display("FAIL apex_down%0d y=%0d landed=%b want y=%0d landed=%b",
                 i, y_a, land_a, down[i], (i == 3));
      end
    end
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    total++;
    if (duck_a !== 1'b1) begin
      bad++; $display("FAIL land_to_duck ducking=%b want 1", duck_a);
    end
    cyc(1, 0, 1, 0);
    total++;
    if (duck_a !== 1'b1 || air_a !== 1'b0) begin
      bad++; $display("FAIL duck_hold ducking=%b air=%b want 1/0", duck_a, air_a);
    end
    cyc(1, 0, 0, 0);
    settle();
  endtask

  task automatic test_freeze();
    int tail[3] = '{7, 4, 0};
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    total++;
    if (y_a !== 8'd9) begin
      bad++; $display("FAIL pre_freeze y=%0d want 9", y_a);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, (i == 2), 0, 1);
      total++;
      if (y_a !== 8'd9 || air_a !== 1'b1) begin
        bad++; $display("FAIL freeze%0d y=%0d air=%b want 9/1", i, y_a, air_a);
      end
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      total++;
      if (y_a !== 8'(tail[i])) begin
        bad++; $display("FAIL resume%0d y=%0d want %0d", i, y_a, tail[i]);
      end
    end
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    total++;
    if (air_a !== 1'b0 || y_a !== 8'd0) begin
      bad++; $display("FAIL land_jump_ignored air=%b y=%0d want 0/0", air_a, y_a);
    end
    cyc(0, 0, 0, 0);
    settle();
  endtask

  task automatic test_clamp_and_reset();
    int hi[5] = '{200, 255, 255, 254, 252};
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    total++;
    if (air_b !== 1'b1 || y_b !== 8'd0) begin
      bad++; $display("FAIL hi_takeoff air=%b y=%0d want 1/0", air_b, y_b);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      total++;
      if (y_b !== 8'(hi[i])) begin
        bad++; $display("FAIL clamp%0d y=%0d want %0d", i, y_b, hi[i]);
      end
    end
    tick = 1'b0; jump = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_out(1) !== 11'd0 || dut_out(0) !== 11'd0) begin
      bad++;
      $display("FAIL async_reset got_a=%h got_b=%h want=000", dut_out(0), dut_out(1));
    end
    #2 rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0);
    total++;
    if (dut_out(1) !== 11'd0 || land_b !== 1'b0) begin
      bad++; $display("FAIL post_reset got_b=%h want=000", dut_out(1));
    end
  endtask

  task automatic test_random();
    bit j = 0, d = 0, t, f;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) j = ~j;
      if ($urandom_range(0, 9) == 0) d = ~d;
      cyc(t, j, d, f);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_out(k) !== model_out(k)) begin
          bad++;
          $display("FAIL random%0d k=%0d got=%h want=%h", i, k, dut_out(k), model_out(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_duck();
    test_apex_duck();
    test_freeze();
    test_clamp_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
